// File: rtl/io_count_checker.sv
// Monitors a 2-bit counter on io_in[1:0], locks after LOCK_STEPS clean increments and counts faults.
// Define IO_COUNT_CHECKER_ERR_STICKY_EN to keep err_flag set until soft clear or rst.
module io_count_checker #(
    parameter int LOCK_STEPS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] io_in,
    output logic [23:0] io_out,
    output logic [23:0] io_oeb
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LOCK_TARGET  = 4'(LOCK_STEPS);

    logic [1:0]  cnt_meta_q, cnt_sync_q;
    logic        clr_meta_q, clr_sync_q;
    state_t      state_q, state_d;
    logic [1:0]  prev_q, prev_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_flag_q, err_flag_d;

    logic change, good_step, bad_step, timeout, err_inc;
    logic unused_in;

    assign unused_in = ^{io_in[23], io_in[21:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_meta_q <= 2'd0;
            cnt_sync_q <= 2'd0;
            clr_meta_q <= 1'b0;
            clr_sync_q <= 1'b0;
            state_q    <= SEARCH;
            prev_q     <= 2'd0;
            good_cnt_q <= 4'd0;
            timer_q    <= 16'd0;
            err_cnt_q  <= 8'd0;
            err_flag_q <= 1'b0;
        end else begin
            cnt_meta_q <= io_in[1:0];
            cnt_sync_q <= cnt_meta_q;
            clr_meta_q <= io_in[22];
            clr_sync_q <= clr_meta_q;
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_cnt_q <= good_cnt_d;
            timer_q    <= timer_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Step classification; 2-bit arithmetic makes 3 -> 0 a good step.
    always_comb begin
        change    = (cnt_sync_q != prev_q);
        good_step = (cnt_sync_q == prev_q + 2'd1);
        bad_step  = change && !good_step;
        timeout   = !change && (timer_q == TIMEOUT_LAST);
        prev_d    = change ? cnt_sync_q : prev_q;
        if (change || timeout) begin
            timer_d = 16'd0;
        end else begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_inc    = 1'b0;
        case (state_q)
            SEARCH: begin
                if (change) begin
                    state_d    = LOCKING;
                    good_cnt_d = 4'd0;
                end
            end
            LOCKING: begin
                if (good_step) begin
                    good_cnt_d = good_cnt_q + 4'd1;
                    if (good_cnt_q + 4'd1 == LOCK_TARGET) begin
                        state_d = LOCKED;
                    end
                end else if (bad_step) begin
                    good_cnt_d = 4'd0;
                end else if (timeout) begin
                    state_d    = SEARCH;
                    good_cnt_d = 4'd0;
                end
            end
            LOCKED: begin
                if (bad_step || timeout) begin
                    state_d = FAULT;
                    err_inc = 1'b1;
                end
            end
            FAULT: begin
                if (change) begin
                    state_d    = LOCKING;
                    good_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = 4'd0;
            end
        endcase
    end

    // Soft clear has priority over a same-cycle increment.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        if (clr_sync_q) begin
            err_cnt_d  = 8'd0;
            err_flag_d = 1'b0;
        end else begin
            if (err_inc && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
`ifdef IO_COUNT_CHECKER_ERR_STICKY_EN
            if (err_inc) begin
                err_flag_d = 1'b1;
            end
`else
            if (err_inc) begin
                err_flag_d = 1'b1;
            end else if (state_d != FAULT) begin
                err_flag_d = 1'b0;
            end
`endif
        end
    end

    assign io_out = {12'd0, cnt_sync_q, err_flag_q, (state_q == LOCKED), err_cnt_q};
    assign io_oeb = 24'hFFF000;

endmodule

// File: tb/tb_io_count_checker.sv
// Directed self-checking bench for io_count_checker (default parameters).
module tb_io_count_checker;

    logic        clk;
    logic        rst;
    logic [23:0] io_in;
    logic [23:0] io_out;
    logic [23:0] io_oeb;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] cur;

    io_count_checker #(
        .LOCK_STEPS(4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_in (io_in),
        .io_out(io_out),
        .io_oeb(io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Called at a negedge; leaves the caller at a negedge after hold cycles.
    task automatic step(input logic [1:0] v, input int hold);
        io_in[1:0] = v;
        cur = v;
        repeat (hold) @(negedge clk);
    endtask

    // Enter LOCKING with one change, then four good steps complete the lock.
    task automatic relock(input int hold);
        for (int i = 0; i < 5; i++) step(cur + 2'd1, hold);
    endtask

    task automatic bad_step(input int hold);
        step(cur + 2'd2, hold);
    endtask

    task automatic soft_clear();
        io_in[22] = 1'b1;
        @(negedge clk);
        io_in[22] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    logic exp_flag_after_leave;

    initial begin
`ifdef IO_COUNT_CHECKER_ERR_STICKY_EN
        exp_flag_after_leave = 1'b1;
`else
        exp_flag_after_leave = 1'b0;
`endif
        rst   = 1'b1;
        io_in = 24'd0;
        cur   = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_io_out", io_out, 32'h0);
        check("reset_io_oeb", io_oeb, 32'hFFF000);
        rst = 1'b0;
        @(negedge clk);

        // First change only enters LOCKING; lock needs four further good steps.
        step(2'd1, 5); step(2'd2, 5); step(2'd3, 5); step(2'd0, 5);
        check("pre_lock_locked", io_out[8], 0);
        step(2'd1, 5);
        check("lock_locked", io_out[8], 1);
        check("lock_err_cnt", io_out[7:0], 0);
        check("lock_last_cnt", io_out[11:10], 1);

        // Bad step 1 -> 3 while locked.
        step(2'd3, 5);
        check("bad_locked", io_out[8], 0);
        check("bad_err_cnt", io_out[7:0], 1);
        check("bad_err_flag", io_out[9], 1);
        step(2'd0, 5);
        check("leave_fault_flag", io_out[9], exp_flag_after_leave);
        check("leave_fault_cnt", io_out[7:0], 1);
        step(2'd1, 5); step(2'd2, 5); step(2'd3, 5);
        check("relock_partial", io_out[8], 0);
        step(2'd0, 5);
        check("relock_locked", io_out[8], 1);
        check("relock_err_cnt", io_out[7:0], 1);

        // Stall timeout while locked: one error, further stalls add nothing.
        repeat (990) @(negedge clk);
        check("stall_before_timeout", io_out[8], 1);
        repeat (15) @(negedge clk);
        check("stall_timeout_locked", io_out[8], 0);
        check("stall_timeout_cnt", io_out[7:0], 2);
        repeat (5000) @(negedge clk);
        check("stall_long_cnt", io_out[7:0], 2);

        // Reach err_cnt=5, relock, then soft clear keeps the lock.
        for (int i = 0; i < 3; i++) begin
            relock(3);
            bad_step(3);
        end
        relock(5);
        check("pre_clear_cnt", io_out[7:0], 5);
        check("pre_clear_locked", io_out[8], 1);
        soft_clear();
        check("clear_cnt", io_out[7:0], 0);
        check("clear_flag", io_out[9], 0);
        check("clear_locked", io_out[8], 1);

        // Soft clear while in FAULT.
        bad_step(5);
        check("fault_flag", io_out[9], 1);
        soft_clear();
        check("fault_clear_flag", io_out[9], 0);
        check("fault_clear_cnt", io_out[7:0], 0);

        // Saturation: 300 lock/bad cycles.
        for (int i = 0; i < 300; i++) begin
            relock(2);
            bad_step(2);
        end
        repeat (3) @(negedge clk);
        check("sat_cnt", io_out[7:0], 255);
        relock(3);
        bad_step(5);
        check("sat_hold_cnt", io_out[7:0], 255);

        // Mid-operation reset abandons the lock without counting an error.
        relock(5);
        check("pre_rst_locked", io_out[8], 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_io_out", io_out, 32'h0);
        check("mid_rst_io_oeb", io_oeb, 32'hFFF000);
        rst = 1'b0;
        step(cur, 5);
        relock(5);
        check("post_rst_locked", io_out[8], 1);
        check("post_rst_cnt", io_out[7:0], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
